// File: rtl/fetch_prefetch_unit.sv
// IF-stage front end: owns the fetch PC, issues in-order imem requests against a
// credit limit, buffers returned words with their PC+1, and feeds IF/ID.
module fetch_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0000
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req,
  output logic [15:0]             imem_addr,
  input  logic                    imem_valid,
  input  logic [15:0]             imem_data,
  input  logic                    redirect,
  input  logic [15:0]             redirect_pc,
  input  logic                    stall,
  output logic [15:0]             inst_out,
  output logic [15:0]             pc_added_out,
  output logic                    inst_valid,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  // Drop counter is wider than the credit window: repeated redirects against a slow
  // memory can stack more discarded responses than DEPTH.
  localparam int unsigned DW = CW + 4;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [15:0]   fetch_pc;
  logic [15:0]   fifo_inst [DEPTH];
  logic [15:0]   fifo_tag  [DEPTH];
  logic [15:0]   tag_q     [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, tq_rd, tq_wr;
  logic [CW-1:0] count, inflight;
  logic [DW-1:0] drop, drop_on_redirect;

  logic credit_ok, issue, resp_drop, resp_take, push, pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    credit_ok        = ({1'b0, count} + {1'b0, inflight}) < DEPTH_W;
    issue            = !rst && !redirect && credit_ok;
    resp_drop        = imem_valid && (drop != '0);
    resp_take        = imem_valid && (drop == '0) && (inflight != '0);
    push             = resp_take && !redirect && !rst;
    pop              = !redirect && !stall && (count != '0);
    drop_on_redirect = drop + DW'(inflight) - DW'(resp_drop || resp_take);
  end

  assign imem_req   = issue;
  assign imem_addr  = fetch_pc;
  assign fifo_count = count;

  // Payload storage carries no reset; validity is tracked by the pointers and counts.
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_q[tq_wr] <= fetch_pc + 16'd1;
    end
    if (push) begin
      fifo_inst[wr_ptr] <= imem_data;
      fifo_tag[wr_ptr]  <= tag_q[tq_rd];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc     <= RESET_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      tq_rd        <= '0;
      tq_wr        <= '0;
      count        <= '0;
      inflight     <= '0;
      drop         <= '0;
      inst_out     <= NOP_INST;
      pc_added_out <= RESET_PC + 16'd1;
      inst_valid   <= 1'b0;
    end else if (redirect) begin
      fetch_pc   <= redirect_pc;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      tq_rd      <= '0;
      tq_wr      <= '0;
      count      <= '0;
      inflight   <= '0;
      drop       <= drop_on_redirect;
      inst_out   <= NOP_INST;
      inst_valid <= 1'b0;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + 16'd1;
        tq_wr    <= ptr_next(tq_wr);
      end
      if (resp_drop) begin
        drop <= drop - DW'(1);
      end
      if (resp_take) begin
        tq_rd <= ptr_next(tq_rd);
      end
      inflight <= inflight + CW'(issue) - CW'(resp_take);
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      count <= count + CW'(push) - CW'(pop);
      if (pop) begin
        rd_ptr       <= ptr_next(rd_ptr);
        inst_out     <= fifo_inst[rd_ptr];
        pc_added_out <= fifo_tag[rd_ptr];
        inst_valid   <= 1'b1;
      end else if (!stall) begin
        inst_out   <= NOP_INST;
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: fixed-latency memory responder, stream scoreboard.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst, redirect, stall;
  logic [15:0] redirect_pc;
  logic        imem_req, imem_valid, inst_valid;
  logic [15:0] imem_addr, imem_data, inst_out, pc_added_out;
  logic [2:0]  fifo_count;

  logic        imem_req2, imem_valid2, inst_valid2, redirect2;
  logic [15:0] imem_addr2, imem_data2, inst_out2, pc_added_out2;
  logic [2:0]  fifo_count2;

  int checks = 0;
  int failures = 0;

  logic        pv [8];
  logic [15:0] pa [8];
  logic        pv2;
  logic [15:0] pa2;
  int          lat = 1;

  logic        req_seen, req2_seen, e_rst, e_redir, e_stall, new_out, bound_chk;
  logic [15:0] addr_seen, addr2_seen, e_rpc, exp_pc;
  logic [32:0] prev;
  int          nvalid = 0;

  fetch_prefetch_unit u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall(stall), .inst_out(inst_out),
    .pc_added_out(pc_added_out), .inst_valid(inst_valid), .fifo_count(fifo_count)
  );

  fetch_prefetch_unit #(.RESET_PC(16'hFFFE)) u_dut2 (
    .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_valid(imem_valid2), .imem_data(imem_data2), .redirect(redirect2),
    .redirect_pc(16'h0000), .stall(stall), .inst_out(inst_out2),
    .pc_added_out(pc_added_out2), .inst_valid(inst_valid2), .fifo_count(fifo_count2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  function automatic int occ();
    int n = 0;
    for (int i = 0; i < 8; i++) n += pv[i] ? 1 : 0;
    return n;
  endfunction

  // One clock: present responses, capture the request, clock, then score outputs.
  task automatic tick();
    imem_valid = pv[0];
    imem_data  = pv[0] ? mem_word(pa[0]) : 16'h0000;
    for (int i = 0; i < 7; i++) begin
      pv[i] = pv[i+1];
      pa[i] = pa[i+1];
    end
    pv[7] = 1'b0;
    imem_valid2 = pv2;
    imem_data2  = pv2 ? mem_word(pa2) : 16'h0000;
    pv2 = 1'b0;
    #1;
    req_seen = imem_req;   addr_seen  = imem_addr;
    req2_seen = imem_req2; addr2_seen = imem_addr2;
    if (imem_req) begin
      pv[lat-1] = 1'b1;
      pa[lat-1] = imem_addr;
    end
    if (imem_req2) begin
      pv2 = 1'b1;
      pa2 = imem_addr2;
    end
    e_rst = rst; e_redir = redirect; e_stall = stall; e_rpc = redirect_pc;
    if (redirect && !rst) begin
      checks++;
      if (imem_req !== 1'b0) begin
        failures++;
        $display("FAIL req_in_redirect: got %b expected 0", imem_req);
      end
    end
    @(posedge clk);
    #1;
    new_out = 1'b0;
    if (e_rst) begin
      exp_pc = 16'h0000;
    end else if (e_redir) begin
      exp_pc = e_rpc;
      checks++;
      if (inst_valid !== 1'b0 || inst_out !== 16'h0000) begin
        failures++;
        $display("FAIL redirect_kill: got valid=%b inst=%h expected valid=0 inst=0000", inst_valid, inst_out);
      end
    end else if (e_stall) begin
      checks++;
      if ({inst_out, pc_added_out, inst_valid} !== prev) begin
        failures++;
        $display("FAIL stall_hold: got %h expected %h", {inst_out, pc_added_out, inst_valid}, prev);
      end
    end else if (inst_valid === 1'b1) begin
      new_out = 1'b1;
      nvalid++;
      checks++;
      if (inst_out !== mem_word(exp_pc) || pc_added_out !== exp_pc + 16'd1) begin
        failures++;
        $display("FAIL stream: got inst=%h pc1=%h expected inst=%h pc1=%h",
                 inst_out, pc_added_out, mem_word(exp_pc), exp_pc + 16'd1);
      end
      exp_pc = exp_pc + 16'd1;
    end else begin
      checks++;
      if (inst_out !== 16'h0000 || pc_added_out !== prev[16:1]) begin
        failures++;
        $display("FAIL empty_out: got inst=%h pc1=%h expected inst=0000 pc1=%h",
                 inst_out, pc_added_out, prev[16:1]);
      end
    end
    prev = {inst_out, pc_added_out, inst_valid};
    if (bound_chk && !rst && !redirect) begin
      checks++;
      if (occ() + int'(fifo_count) > 4 || (occ() + int'(fifo_count) == 4 && imem_req !== 1'b0)) begin
        failures++;
        $display("FAIL credit_bound: got outstanding=%0d req=%b expected <=4 and no req at 4",
                 occ() + int'(fifo_count), imem_req);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect2 = 1'b0; redirect_pc = 16'h0000;
    bound_chk = 1'b0;
    for (int i = 0; i < 8; i++) begin pv[i] = 1'b0; pa[i] = 16'h0000; end
    pv2 = 1'b0; pa2 = 16'h0000;
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst_out !== 16'h0000 ||
        pc_added_out !== 16'h0001 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: got req=%b v=%b inst=%h pc1=%h cnt=%0d expected 0 0 0000 0001 0",
               imem_req, inst_valid, inst_out, pc_added_out, fifo_count);
    end
    checks++;
    if (pc_added_out2 !== 16'hFFFF || inst_valid2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_pc_param: got pc1=%h v=%b expected FFFF 0", pc_added_out2, inst_valid2);
    end
  endtask

  // Also covers the RESET_PC=FFFE wrap through the second instance.
  task automatic test_sequential();
    logic [15:0] want_addr  [5] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
    logic [15:0] want_addr2 [5] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
    logic [15:0] want_pc2   [5] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001};
    logic        want_v     [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (req_seen !== 1'b1 || addr_seen !== want_addr[i]) begin
        failures++;
        $display("FAIL fetch_addr[%0d]: got req=%b addr=%h expected 1 %h", i, req_seen, addr_seen, want_addr[i]);
      end
      checks++;
      if (inst_valid !== want_v[i]) begin
        failures++;
        $display("FAIL first_valid[%0d]: got %b expected %b", i, inst_valid, want_v[i]);
      end
      checks++;
      if (req2_seen !== 1'b1 || addr2_seen !== want_addr2[i] || pc_added_out2 !== want_pc2[i] ||
          (want_v[i] && inst_out2 !== mem_word(want_pc2[i] - 16'd1))) begin
        failures++;
        $display("FAIL wrap[%0d]: got addr=%h pc1=%h inst=%h expected addr=%h pc1=%h", i,
                 addr2_seen, pc_added_out2, inst_out2, want_addr2[i], want_pc2[i]);
      end
    end
  endtask

  task automatic test_stall_fill();
    logic [15:0] pc_before;
    bound_chk = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (fifo_count !== 3'd4 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL stall_fill: got cnt=%0d req=%b expected 4 0", fifo_count, imem_req);
    end
    stall = 1'b0;
    pc_before = exp_pc;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (exp_pc !== pc_before + 16'd4) begin
      failures++;
      $display("FAIL stall_release: got %h expected %h", exp_pc, pc_before + 16'd4);
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_redirect();
    int n;
    bound_chk = 1'b0;
    lat = 3;
    n = 0;
    while (occ() < 2 && n < 20) begin tick(); n++; end
    checks++;
    if (occ() < 2) begin
      failures++;
      $display("FAIL inflight_setup: got %0d expected >=2", occ());
    end
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    tick();
    checks++;
    if (req_seen !== 1'b1 || addr_seen !== 16'h0040) begin
      failures++;
      $display("FAIL redirect_fetch: got req=%b addr=%h expected 1 0040", req_seen, addr_seen);
    end
    n = 0;
    while (!new_out && n < 20) begin tick(); n++; end
    checks++;
    if (!new_out || pc_added_out !== 16'h0041 || inst_out !== mem_word(16'h0040)) begin
      failures++;
      $display("FAIL redirect_first: got v=%b pc1=%h inst=%h expected 1 0041 %h",
               new_out, pc_added_out, inst_out, mem_word(16'h0040));
    end
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_redirect_stall();
    int n;
    stall = 1'b1;
    tick();
    tick();
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL redirect_over_stall: got %b expected 0", inst_valid);
    end
    redirect = 1'b0;
    tick();
    checks++;
    if (req_seen !== 1'b1 || addr_seen !== 16'h0100) begin
      failures++;
      $display("FAIL redirect_stall_pc: got req=%b addr=%h expected 1 0100", req_seen, addr_seen);
    end
    stall = 1'b0;
    n = 0;
    while (!new_out && n < 20) begin tick(); n++; end
    checks++;
    if (!new_out || pc_added_out !== 16'h0101) begin
      failures++;
      $display("FAIL redirect_stall_first: got v=%b pc1=%h expected 1 0101", new_out, pc_added_out);
    end
  endtask

  task automatic test_random_stall();
    int start;
    start = nvalid;
    for (int i = 0; i < 300; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      bound_chk = (i >= 6);
      tick();
    end
    stall = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (nvalid - start < 100) begin
      failures++;
      $display("FAIL random_progress: got %0d expected >=100", nvalid - start);
    end
    bound_chk = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || fifo_count !== 3'd0 || pc_added_out !== 16'h0001) begin
      failures++;
      $display("FAIL reset_mid: got req=%b v=%b cnt=%0d pc1=%h expected 0 0 0 0001",
               imem_req, inst_valid, fifo_count, pc_added_out);
    end
    rst = 1'b0;
    n = 0;
    while (!new_out && n < 20) begin tick(); n++; end
    checks++;
    if (!new_out || pc_added_out !== 16'h0001 || inst_out !== mem_word(16'h0000)) begin
      failures++;
      $display("FAIL reset_mid_first: got v=%b pc1=%h inst=%h expected 1 0001 %h",
               new_out, pc_added_out, inst_out, mem_word(16'h0000));
    end
    for (int i = 0; i < 5; i++) tick();
  endtask

  initial begin
    imem_valid = 1'b0; imem_data = 16'h0000; imem_valid2 = 1'b0; imem_data2 = 16'h0000;
    exp_pc = 16'h0000; prev = '0;
    test_reset();
    test_sequential();
    test_stall_fill();
    test_redirect();
    test_redirect_stall();
    test_random_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
